keypoint_scan_ctrl: RTL
=======================

Name: keypoint_scan_ctrl

Overview:
Parametrised successor of the two-scale DoG keypoint detect/filter controller.
- Sequences row reads from the pyramid SRAMs and controls the line-buffer shift.
- Steps the column pointer, takes per-scale candidate flags from NUM_SCALES external detect_keypoint instances, and runs a variable-length filter pass over only the scales that fired.
- Writes {row,col} records into per-scale keypoint SRAMs, with address saturation and overflow flags.

Parameters:
NUM_SCALES, 2, number of DoG scales checked per pixel (1..8)
IMG_ROWS, 480, image height in rows
IMG_COLS, 640, image width in columns
ROW_W, 9, row address / record row-field width
COL_W, 10, column / record column-field width
KP_ADDR_W, 11, keypoint SRAM address width per scale

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a frame scan; sampled only in IDLE
filter_on  in  1  enable edge/contrast filter pass; sampled per candidate column
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of frame
row_addr  out  ROW_W  row address to img and all blur SRAMs (shared)
buffer_we  out  1  line-buffer shift strobe
cur_col  out  COL_W  column under test, to detectors and filter
cand  in  NUM_SCALES  candidate flag per scale for (row_addr-1, cur_col)
filt_sel  out  3  scale index whose rows the filter mux presents
filt_valid  in  1  combinational filter verdict for filt_sel at cur_col
kp_we  out  NUM_SCALES  per-scale keypoint SRAM write enable
kp_addr  out  NUM_SCALES*KP_ADDR_W  packed per-scale write addresses
kp_din  out  ROW_W+COL_W  record {row_addr-1, cur_col}, shared by all scales
overflow  out  NUM_SCALES  sticky: scale SRAM full, later writes dropped

Behaviour:
- Reset values:
  - state IDLE; row_addr=0; cur_col=1; pending=0.
  - kp_we=0, kp_addr=0, kp_din=0, overflow=0, filt_sel=0.
  - done=0, buffer_we=0.
- rst asserted mid-frame aborts immediately to the reset values; there is no partial-frame completion.
- States: IDLE, PRIME0, PRIME1, DETECT, FILTER, NEXT_ROW, BUFFER, DONE.
- IDLE:
  - Stays until start=1.
  - On start: kp_addr=0, overflow=0, row_addr=0, go to PRIME0.
  - start while busy is ignored.
- PRIME0: buffer_we=1; row_addr<=1; go to PRIME1.
- PRIME1: buffer_we=1; row_addr<=2; go to DETECT.
  - After PRIME1, two rows are buffered and the third is on SRAM dout; the centre row is row_addr-1.
- DETECT, one column per cycle:
  - cand==0: cur_col increments; if cur_col==IMG_COLS-2, go to NEXT_ROW instead.
  - cand!=0 and filter_on=0: the next cycle asserts kp_we[i] for every set cand[i] (non-overflowed), kp_din={row_addr-1,cur_col}; the column advances as in the cand==0 case.
  - cand!=0 and filter_on=1: pending<=cand; go to FILTER; cur_col is held.
- FILTER, one cycle per set bit of pending:
  - filt_sel = lowest set bit of pending.
  - If filt_valid=1, the next cycle asserts kp_we[filt_sel] with the record.
  - Clear that bit of pending.
  - When the last bit is cleared, advance the column as in DETECT, or go to NEXT_ROW at the last column.
  - Latency: popcount(cand) cycles; DETECT cycle plus FILTER cycles never exceed NUM_SCALES+1 per column.
- NEXT_ROW:
  - If row_addr==IMG_ROWS-1, go to DONE.
  - Otherwise buffer_we=1, row_addr++, cur_col<=1, go to BUFFER.
- BUFFER: single wait cycle for SRAM read latency; go to DETECT.
- DONE: done=1 for one cycle; row_addr<=0; go to IDLE.
- Scan range:
  - Columns 1..IMG_COLS-2.
  - Centre rows 1..IMG_ROWS-2.
- Addressing:
  - kp_addr[i] increments on each kp_we[i].
  - A write at address 2^KP_ADDR_W-1 completes, then overflow[i] is set and kp_addr[i] holds.
  - While overflow[i]=1, kp_we[i] is suppressed; other scales are unaffected.
- Simultaneous candidates in one column produce writes in ascending scale order, one per cycle when filtering, or all in the same cycle when unfiltered.

Optional Feature:
KP_BORDER_EN
- With the macro: adds parameter BORDER (default 4).
  - cand is masked to 0 when the centre row < BORDER or > IMG_ROWS-1-BORDER.
  - cand is also masked when cur_col < BORDER or > IMG_COLS-1-BORDER.
  - Masked columns take the cand==0 path: one cycle each, no FILTER entry, no write.
- Without the macro: only the inherent 1-pixel border is excluded.

Test Plan:
- IMG_ROWS=6, IMG_COLS=8, cand=0 always; start high in cycle 0 -> buffer_we high in cycles 1,2,9,17,25; done high only in cycle 33; zero kp_we; busy low from cycle 34.
- NUM_SCALES=2, filter_on=0, cand=2'b11 at centre row 3, col 5 -> in the following cycle kp_we=2'b11, kp_din={3,5}; both kp_addr become 1; no FILTER state entered.
- NUM_SCALES=4, filter_on=1, cand=4'b1010, filt_valid=1 then 0 -> filt_sel=1 then 3; single write to scale 1; column held 2 cycles and then advances.
- KP_ADDR_W=2, continuous cand[0]=1, filter_on=0 -> writes at addresses 0..3; overflow[0] set after the 4th write; no further kp_we[0]; scale 1 still writes.
- rst pulsed during FILTER of row 2 -> all outputs immediately at reset values; a new start rescans from row 0 with kp_addr=0.
- KP_BORDER_EN, BORDER=2, IMG_COLS=8, cand=1 everywhere -> writes only for cols 2..5 and centre rows 2..IMG_ROWS-3.

Source files
------------

// File: rtl/keypoint_scan_ctrl_if.sv
// Handshake/bus bundle between the keypoint scan controller and its detectors, filter mux and SRAMs.
// The master modport is the controller side.
interface keypoint_scan_ctrl_if #(
  parameter int unsigned NUM_SCALES = 2,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned KP_ADDR_W  = 11
);
  logic                            start;
  logic                            filter_on;
  logic                            busy;
  logic                            done;
  logic [ROW_W-1:0]                row_addr;
  logic                            buffer_we;
  logic [COL_W-1:0]                cur_col;
  logic [NUM_SCALES-1:0]           cand;
  logic [2:0]                      filt_sel;
  logic                            filt_valid;
  logic [NUM_SCALES-1:0]           kp_we;
  logic [NUM_SCALES*KP_ADDR_W-1:0] kp_addr;
  logic [ROW_W+COL_W-1:0]          kp_din;
  logic [NUM_SCALES-1:0]           overflow;

  modport master (
    input  start, filter_on, cand, filt_valid,
    output busy, done, row_addr, buffer_we, cur_col, filt_sel,
           kp_we, kp_addr, kp_din, overflow
  );

  modport slave (
    output start, filter_on, cand, filt_valid,
    input  busy, done, row_addr, buffer_we, cur_col, filt_sel,
           kp_we, kp_addr, kp_din, overflow
  );
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// Multi-scale DoG keypoint scan controller: row/line-buffer sequencing, column stepping, filter pass, keypoint SRAM writes.
// Optional macro KP_BORDER_EN adds parameter BORDER and masks candidates inside that border.
module keypoint_scan_ctrl #(
  parameter int unsigned NUM_SCALES = 2,
  parameter int unsigned IMG_ROWS   = 480,
  parameter int unsigned IMG_COLS   = 640,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned KP_ADDR_W  = 11
`ifdef KP_BORDER_EN
  , parameter int unsigned BORDER   = 4
`endif
) (
  input logic clk,
  input logic rst,
  keypoint_scan_ctrl_if.master bus
);

  localparam int unsigned REC_W = ROW_W + COL_W;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME0, S_PRIME1, S_DETECT, S_FILTER, S_NEXT_ROW, S_BUFFER, S_DONE
  } state_t;

  state_t                                r_state, w_state_nxt;
  logic [ROW_W-1:0]                      r_row_addr, w_row_addr_nxt;
  logic [COL_W-1:0]                      r_cur_col, w_cur_col_nxt;
  logic [NUM_SCALES-1:0]                 r_pending, w_pending_nxt;
  logic [2:0]                            r_filt_sel, w_filt_sel_nxt;
  logic [NUM_SCALES-1:0]                 r_kp_we, w_kp_we_nxt;
  logic [REC_W-1:0]                      r_kp_din;
  logic [NUM_SCALES-1:0][KP_ADDR_W-1:0]  r_kp_addr;
  logic [NUM_SCALES-1:0]                 r_overflow;
  logic                                  r_busy, r_done, r_buffer_we;

  logic [ROW_W-1:0]      w_center;
  logic                  w_in_win;
  logic [NUM_SCALES-1:0] w_cand;
  logic [NUM_SCALES-1:0] w_full;
  logic [NUM_SCALES-1:0] w_pending_left;
  logic                  w_last_col, w_last_row, w_col_done;
  state_t                w_row_end_state;

  function automatic logic [2:0] lsb_idx(input logic [NUM_SCALES-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SCALES - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_center = r_row_addr - ROW_W'(1);

`ifdef KP_BORDER_EN
  assign w_in_win = (w_center  >= ROW_W'(BORDER)) && (w_center  <= ROW_W'(IMG_ROWS - 1 - BORDER)) &&
                    (r_cur_col >= COL_W'(BORDER)) && (r_cur_col <= COL_W'(IMG_COLS - 1 - BORDER));
`else
  assign w_in_win = 1'b1;
`endif

  assign w_cand         = w_in_win ? bus.cand : '0;
  assign w_last_col     = (r_cur_col == COL_W'(IMG_COLS - 2));
  assign w_last_row     = (r_row_addr == ROW_W'(IMG_ROWS - 1));
  assign w_pending_left = r_pending & (r_pending - NUM_SCALES'(1));
  // The last centre row finishes straight into DONE; earlier rows go through NEXT_ROW.
  assign w_row_end_state = w_last_row ? S_DONE : S_NEXT_ROW;

  // A scale is full once overflowed, or while its write at the top address is still in flight.
  always_comb begin
    for (int i = 0; i < NUM_SCALES; i++) begin
      w_full[i] = r_overflow[i] | (r_kp_we[i] & (&r_kp_addr[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.start) w_state_nxt = S_PRIME0;
      S_PRIME0:   w_state_nxt = S_PRIME1;
      S_PRIME1:   w_state_nxt = S_DETECT;
      S_DETECT: begin
        if ((w_cand != '0) && bus.filter_on) w_state_nxt = S_FILTER;
        else if (w_last_col)                 w_state_nxt = w_row_end_state;
      end
      S_FILTER: begin
        if (w_pending_left == '0) w_state_nxt = w_last_col ? w_row_end_state : S_DETECT;
      end
      S_NEXT_ROW: w_state_nxt = w_last_row ? S_DONE : S_BUFFER;
      S_BUFFER:   w_state_nxt = S_DETECT;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_row_addr_nxt = r_row_addr;
    w_cur_col_nxt  = r_cur_col;
    w_pending_nxt  = r_pending;
    w_kp_we_nxt    = '0;
    w_col_done     = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) w_row_addr_nxt = '0;
      S_PRIME0: w_row_addr_nxt = ROW_W'(1);
      S_PRIME1: w_row_addr_nxt = ROW_W'(2);
      S_DETECT: begin
        if ((w_cand != '0) && bus.filter_on) begin
          w_pending_nxt = w_cand;
        end else begin
          w_kp_we_nxt = w_cand & ~w_full;
          w_col_done  = 1'b1;
        end
      end
      S_FILTER: begin
        if (bus.filt_valid) w_kp_we_nxt = (NUM_SCALES'(1) << r_filt_sel) & ~w_full;
        w_pending_nxt = w_pending_left;
        w_col_done    = (w_pending_left == '0);
      end
      S_NEXT_ROW: begin
        if (!w_last_row) begin
          w_row_addr_nxt = r_row_addr + ROW_W'(1);
          w_cur_col_nxt  = COL_W'(1);
        end
      end
      S_DONE:   w_row_addr_nxt = '0;
      default:  ;
    endcase
    if (w_col_done) w_cur_col_nxt = w_last_col ? COL_W'(1) : r_cur_col + COL_W'(1);
    w_filt_sel_nxt = (w_pending_nxt != '0) ? lsb_idx(w_pending_nxt) : r_filt_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_addr  <= '0;
      r_cur_col   <= COL_W'(1);
      r_pending   <= '0;
      r_filt_sel  <= '0;
      r_kp_we     <= '0;
      r_kp_din    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_buffer_we <= 1'b0;
    end else begin
      r_row_addr  <= w_row_addr_nxt;
      r_cur_col   <= w_cur_col_nxt;
      r_pending   <= w_pending_nxt;
      r_filt_sel  <= w_filt_sel_nxt;
      r_kp_we     <= w_kp_we_nxt;
      if (w_kp_we_nxt != '0) r_kp_din <= {w_center, r_cur_col};
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_buffer_we <= (w_state_nxt == S_PRIME0) || (w_state_nxt == S_PRIME1) ||
                     (w_state_nxt == S_NEXT_ROW);
    end
  end

  // Per-scale write pointer: advances after each write, freezes at the top address once overflowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kp_addr  <= '0;
      r_overflow <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_kp_addr  <= '0;
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_SCALES; i++) begin
        if (r_kp_we[i]) begin
          if (&r_kp_addr[i]) r_overflow[i] <= 1'b1;
          else               r_kp_addr[i]  <= r_kp_addr[i] + KP_ADDR_W'(1);
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.row_addr  = r_row_addr;
  assign bus.buffer_we = r_buffer_we;
  assign bus.cur_col   = r_cur_col;
  assign bus.filt_sel  = r_filt_sel;
  assign bus.kp_we     = r_kp_we;
  assign bus.kp_addr   = r_kp_addr;
  assign bus.kp_din    = r_kp_din;
  assign bus.overflow  = r_overflow;

endmodule
